// File: rtl/ft_pkg.sv
// Shared definitions for the FT2232H synchronous FIFO transmit engine.
//   FT_BYTE_W      width of the device data bus
//   FT_CNT_W       width of the transferred-byte counter
//   flush_state_t  states of the send-immediate (SIWU#) flush FSM
package ft_pkg;

  localparam int FT_BYTE_W = 8;
  localparam int FT_CNT_W  = 32;

  typedef enum logic [1:0] {
    FL_IDLE  = 2'd0,
    FL_ARMED = 2'd1,
    FL_PULSE = 2'd2
  } flush_state_t;

endpackage

// File: rtl/ft_sync_fifo.sv
// Single-clock word FIFO with first-word-fall-through read data.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (pointers/level only)
//   wr_en        push wr_data (ignored while full)
//   wr_data      word to push
//   rd_en        pop the head word (ignored while empty)
//   rd_data      current head word, valid whenever empty=0
//   level        number of words stored, 0..DEPTH
//   full, empty  level==DEPTH / level==0
module ft_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             push;
  logic             pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;
  assign level   = count;
  assign rd_data = mem[rd_ptr];

  // Storage needs no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ft_sync_tx.sv
// Transmit engine for the FT2232H 245-style synchronous FIFO interface.
// Buffers IN_BYTES-wide words, serialises them LSB-first onto the device
// data bus under control of TXE#, and pulses SIWU# after FLUSH_IDLE idle
// cycles so short packets are pushed out of the device buffer.
// Ports:
//   comm_clk   60 MHz device clock, all logic on its rising edge
//   rst_n      asynchronous active-low reset
//   in_data    input word, byte 0 in bits [7:0]
//   in_valid   in_data valid
//   in_ready   buffer can accept a word
//   txe        device TXE#, 0 = device can take a byte
//   data       byte presented to the device
//   wr         device WR#, active low (combinational in txe)
//   siwu       device SIWU#, active-low one-cycle pulse
//   level      words held in the buffer (not counting the serialiser)
//   tx_count   bytes transferred, wraps modulo 2^32
module ft_sync_tx
  import ft_pkg::*;
#(
  parameter int IN_BYTES   = 1,
  parameter int DEPTH      = 16,
  parameter int FLUSH_IDLE = 64
) (
  input  logic                         comm_clk,
  input  logic                         rst_n,
  input  logic [IN_BYTES*FT_BYTE_W-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         txe,
  output logic [FT_BYTE_W-1:0]         data,
  output logic                         wr,
  output logic                         siwu,
  output logic [$clog2(DEPTH):0]       level,
  output logic [FT_CNT_W-1:0]          tx_count
);

  localparam int WORD_W = IN_BYTES * FT_BYTE_W;
  localparam int IDX_W  = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(IN_BYTES - 1);
  localparam logic [FT_CNT_W-1:0] FL_LAST  =
    FT_CNT_W'((FLUSH_IDLE > 0) ? (FLUSH_IDLE - 1) : 0);

  function automatic logic [FT_BYTE_W-1:0] byte_of(
    input logic [WORD_W-1:0] w,
    input logic [IDX_W-1:0]  i
  );
    logic [WORD_W-1:0] s;
    s = w >> (int'(i) * FT_BYTE_W);
    return s[FT_BYTE_W-1:0];
  endfunction

  logic [WORD_W-1:0]    head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 accept;
  logic                 load;
  logic                 xfer;
  logic                 last_byte;
  logic                 idle;

  logic [WORD_W-1:0]    word_q;
  logic [IDX_W-1:0]     idx;
  logic                 byte_valid;
  logic [FT_BYTE_W-1:0] data_q;

  flush_state_t         fl_state;
  flush_state_t         fl_state_d;
  logic [FT_CNT_W-1:0]  idle_cnt;
  logic [FT_CNT_W-1:0]  idle_cnt_d;
  logic                 siwu_q;

  assign in_ready  = ~fifo_full;
  assign accept    = in_valid & ~fifo_full;
  assign xfer      = byte_valid & ~txe;
  assign wr        = ~xfer;
  assign last_byte = (idx == LAST_IDX);
  // Load into an empty serialiser, or reload straight after the last byte
  // so that back-to-back words stream with no bubble.
  assign load      = ~fifo_empty & (~byte_valid | (xfer & last_byte));
  assign idle      = ~byte_valid & fifo_empty;
  assign data      = data_q;
  assign siwu      = siwu_q;

  ft_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (comm_clk),
    .rst_n   (rst_n),
    .wr_en   (accept),
    .wr_data (in_data),
    .rd_en   (load),
    .rd_data (head),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Serialiser and byte counter; data_q holds its value while no byte is valid.
  always_ff @(posedge comm_clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q     <= '0;
      idx        <= '0;
      byte_valid <= 1'b0;
      data_q     <= '0;
      tx_count   <= '0;
    end else begin
      if (xfer) tx_count <= tx_count + 1'b1;
      if (load) begin
        word_q     <= head;
        idx        <= '0;
        byte_valid <= 1'b1;
        data_q     <= head[FT_BYTE_W-1:0];
      end else if (xfer) begin
        if (!last_byte) begin
          idx    <= idx + 1'b1;
          data_q <= byte_of(word_q, idx + 1'b1);
        end else begin
          byte_valid <= 1'b0;
        end
      end
    end
  end

  // Flush FSM: the idle counter only runs while nothing is buffered or held.
  always_comb begin
    fl_state_d = fl_state;
    idle_cnt_d = idle_cnt;
    case (fl_state)
      FL_IDLE: begin
        if ((FLUSH_IDLE != 0) && xfer) begin
          fl_state_d = FL_ARMED;
          idle_cnt_d = '0;
        end
      end
      FL_ARMED: begin
        if (xfer || !idle) begin
          idle_cnt_d = '0;
        end else if (idle_cnt == FL_LAST) begin
          fl_state_d = FL_PULSE;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt + 1'b1;
        end
      end
      FL_PULSE: begin
        idle_cnt_d = '0;
        fl_state_d = xfer ? FL_ARMED : FL_IDLE;
      end
      default: begin
        fl_state_d = FL_IDLE;
        idle_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge comm_clk or negedge rst_n) begin
    if (!rst_n) begin
      fl_state <= FL_IDLE;
      idle_cnt <= '0;
      siwu_q   <= 1'b1;
    end else begin
      fl_state <= fl_state_d;
      idle_cnt <= idle_cnt_d;
      siwu_q   <= (fl_state_d != FL_PULSE);
    end
  end

endmodule

// File: tb/tb_ft_sync_tx.sv
module tb_ft_sync_tx;

  localparam int IN_BYTES   = 2;
  localparam int DEPTH      = 4;
  localparam int FLUSH_IDLE = 5;

  logic        comm_clk = 1'b0;
  logic        rst_n    = 1'b0;
  logic [15:0] in_data  = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        txe      = 1'b1;
  logic [7:0]  data;
  logic        wr;
  logic        siwu;
  logic [2:0]  level;
  logic [31:0] tx_count;

  always #5 comm_clk = ~comm_clk;

  ft_sync_tx #(
    .IN_BYTES   (IN_BYTES),
    .DEPTH      (DEPTH),
    .FLUSH_IDLE (FLUSH_IDLE)
  ) dut (
    .comm_clk (comm_clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .txe      (txe),
    .data     (data),
    .wr       (wr),
    .siwu     (siwu),
    .level    (level),
    .tx_count (tx_count)
  );

  int          vec_cnt   = 0;
  int          miscmp    = 0;
  int          cyc       = 0;
  int          last_xfer = 0;
  int          pulse_cnt = 0;
  logic        prev_siwu = 1'b1;
  logic [7:0]  exp_q[$];
  logic [31:0] exp_cnt   = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge comm_clk) cyc <= cyc + 1;

  // Scoreboard: bytes queued on accept, checked as they are transferred.
  always @(negedge comm_clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_cnt   = '0;
      prev_siwu = 1'b1;
    end else begin
      if (!siwu) begin
        pulse_cnt++;
        chk("siwu_delay", cyc - last_xfer, FLUSH_IDLE);
        chk("siwu_width", {31'b0, prev_siwu}, 32'd1);
      end
      prev_siwu = siwu;
      if (txe) chk("wr_gated", {31'b0, wr}, 32'd1);
      if (!wr) begin
        if (exp_q.size() == 0) begin
          chk("xfer_unexpected", {31'b0, wr}, 32'd1);
        end else begin
          chk("data", {24'b0, data}, {24'b0, exp_q.pop_front()});
        end
        chk("tx_count_run", tx_count, exp_cnt);
        exp_cnt   = exp_cnt + 1;
        last_xfer = cyc + 1;
      end
      if (in_valid && in_ready) begin
        for (int b = 0; b < IN_BYTES; b++) exp_q.push_back(in_data[8*b +: 8]);
      end
    end
  end

  task automatic push_word(input logic [15:0] w);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge comm_clk);
      acc = in_ready;
      @(posedge comm_clk);
      #1;
      n++;
    end
    if (!acc) chk("push_timeout", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge comm_clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int pc0;
    int n_acc;

    // Reset values
    repeat (2) @(posedge comm_clk);
    #1;
    txe = 1'b0;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_data",     {24'b0, data},     32'h00);
    chk("rst_wr",       {31'b0, wr},       32'd1);
    chk("rst_siwu",     {31'b0, siwu},     32'd1);
    chk("rst_level",    {29'b0, level},    32'd0);
    chk("rst_tx_count", tx_count,          32'd0);
    @(posedge comm_clk);
    #1;
    rst_n = 1'b1;

    // Basic word with latency, then flush pulse after idle
    pc0 = pulse_cnt;
    push_word(16'hA55A);
    @(negedge comm_clk);
    chk("lat_load", {31'b0, wr}, 32'd1);
    @(negedge comm_clk);
    chk("lat_first_wr",   {31'b0, wr},   32'd0);
    chk("lat_first_data", {24'b0, data}, 32'h5A);
    wait_drain(20);
    @(negedge comm_clk);
    chk("basic_count", tx_count, 32'd2);
    repeat (15) @(posedge comm_clk);
    #1;
    chk("flush_pulse_once", pulse_cnt - pc0, 32'd1);

    // New data 3 cycles after the last transfer restarts the idle timer
    pc0 = pulse_cnt;
    push_word(16'h1234);
    wait_drain(20);
    repeat (2) @(posedge comm_clk);
    #1;
    push_word(16'h5678);
    wait_drain(20);
    chk("flush_no_early", pulse_cnt - pc0, 32'd0);
    repeat (12) @(posedge comm_clk);
    #1;
    chk("flush_restart", pulse_cnt - pc0, 32'd1);

    // txe toggling mid-word
    txe = 1'b1;
    push_word(16'h0100);
    push_word(16'h0302);
    for (int i = 0; i < 10; i++) begin
      txe = ~txe;
      repeat (3) @(posedge comm_clk);
      #1;
    end
    txe = 1'b0;
    wait_drain(50);
    @(negedge comm_clk);
    chk("toggle_count", tx_count, 32'd10);

    // Fill to full with txe held off, then drain with no gaps
    repeat (10) @(posedge comm_clk);
    #1;
    txe      = 1'b1;
    n_acc    = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 16'hB000 + 16'(i * 16'h0111);
      @(negedge comm_clk);
      if (!in_ready) break;
      n_acc++;
      @(posedge comm_clk);
      #1;
    end
    chk("full_accepts", n_acc, 32'd5);
    chk("full_level",   {29'b0, level},    32'd4);
    chk("full_ready",   {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge comm_clk);
      #1;
      @(negedge comm_clk);
      chk("full_hold_level", {29'b0, level}, 32'd4);
    end
    @(posedge comm_clk);
    #1;
    in_valid = 1'b0;
    txe      = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge comm_clk);
      chk("drain_nogap", {31'b0, wr}, 32'd0);
    end
    @(negedge comm_clk);
    chk("drain_end",   {31'b0, wr}, 32'd1);
    chk("drain_count", tx_count,    32'd20);

    // Asynchronous reset mid-word with three words buffered
    repeat (10) @(posedge comm_clk);
    #1;
    txe = 1'b1;
    for (int i = 0; i < 4; i++) push_word(16'hC000 + 16'(i));
    chk("pre_rst_level", {29'b0, level}, 32'd3);
    txe = 1'b0;
    @(posedge comm_clk);
    #1;
    txe = 1'b1;
    @(posedge comm_clk);
    #1;
    chk("pre_rst_level2", {29'b0, level}, 32'd3);
    txe = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_wr",       {31'b0, wr},       32'd1);
    chk("arst_level",    {29'b0, level},    32'd0);
    chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("arst_tx_count", tx_count,          32'd0);
    chk("arst_data",     {24'b0, data},     32'h00);
    @(posedge comm_clk);
    #1;
    rst_n = 1'b1;

    // Streaming: 1000 random words with txe held low
    for (int i = 0; i < 1000; i++) push_word(16'($urandom));
    wait_drain(200);
    @(negedge comm_clk);
    chk("stream_count", tx_count, 32'd2000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
